// File: rtl/receive_state_machine_pkg.sv
// Shared definitions for the eUSCI_A UART receiver: state encodings, default
// oversampling factor, latched frame configuration and data alignment helper.
package receive_state_machine_pkg;

  localparam int RX_OS_DEFAULT = 16;

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  typedef struct packed {
    logic pen;
    logic par;
    logic msb;
    logic sevenBit;
    logic spb;
    logic rxeie;
  } rxCfg_t;

  // LSB-first 7-bit frames end up in [7:1] of the shifter, so shift them down.
  function automatic logic [7:0] alignData(input logic [7:0] sh, input logic msb,
                                           input logic sevenBit);
    if (!sevenBit)
      return sh;
    else if (msb)
      return {1'b0, sh[6:0]};
    else
      return {1'b0, sh[7:1]};
  endfunction

endpackage

// File: rtl/receive_state_machine_if.sv
// Bus between the eUSCI register block (master) and the UART receiver (slave):
// format controls, serial line, RXIFG status and the character/flag strobes.
interface receive_state_machine_if;
  logic       wUCPEN;
  logic       wUCPAR;
  logic       wUCMSB;
  logic       wUC7BIT;
  logic       wUCSPB;
  logic       wUCRXEIE;
  logic       Rx;
  logic       iRXIFG;
  logic [7:0] RxData;
  logic       setRXIFG;
  logic       setUCPE;
  logic       setUCFE;
  logic       setUCOE;
  logic       RxBusy;

  modport master (
    output wUCPEN, wUCPAR, wUCMSB, wUC7BIT, wUCSPB, wUCRXEIE, Rx, iRXIFG,
    input  RxData, setRXIFG, setUCPE, setUCFE, setUCOE, RxBusy
  );

  modport slave (
    input  wUCPEN, wUCPAR, wUCMSB, wUC7BIT, wUCSPB, wUCRXEIE, Rx, iRXIFG,
    output RxData, setRXIFG, setUCPE, setUCFE, setUCOE, RxBusy
  );
endinterface

// File: rtl/receive_state_machine_uart_rx_sampler.sv
// Rx front end: two-flop synchroniser, falling-edge detect, oversample counter
// and three-point majority vote around the middle of each bit.
module uart_rx_sampler #(
  parameter int OS    = 16,
  parameter int CNT_W = 4
) (
  input  logic BITCLK,
  input  logic reset,
  input  logic Rx,
  input  logic restart,
  input  logic run,
  output logic startEdge,
  output logic bitSample,
  output logic bitValid,
  output logic bitEnd
);

  localparam logic [CNT_W-1:0] MID_LO = CNT_W'(OS/2 - 1);
  localparam logic [CNT_W-1:0] MID    = CNT_W'(OS/2);
  localparam logic [CNT_W-1:0] MID_HI = CNT_W'(OS/2 + 1);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(OS - 1);

  logic             rs1;
  logic             rs;
  logic             rsQ;
  logic             sampleA;
  logic             sampleB;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge BITCLK or negedge reset) begin
    if (!reset) begin
      rs1 <= 1'b1;
      rs  <= 1'b1;
      rsQ <= 1'b1;
    end else begin
      rs1 <= Rx;
      rs  <= rs1;
      rsQ <= rs;
    end
  end

  // The counter is phase-locked to the accepted start edge and free-runs per bit.
  always_ff @(posedge BITCLK or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      sampleA <= 1'b1;
      sampleB <= 1'b1;
    end else if (restart) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (cnt == MID_LO)
        sampleA <= rs;
      if (cnt == MID)
        sampleB <= rs;
    end
  end

  assign startEdge = rsQ & ~rs;
  assign bitValid  = run && (cnt == MID_HI);
  assign bitEnd    = run && (cnt == LAST);
  assign bitSample = (sampleA & sampleB) | (sampleA & rs) | (sampleB & rs);

endmodule

// File: rtl/receive_state_machine.sv
// eUSCI_A UART receiver: frame FSM, data shifter, parity/stop checking and
// registered completion strobes towards the register block.
module receive_state_machine
  import receive_state_machine_pkg::*;
#(
  parameter int OS    = RX_OS_DEFAULT,
  parameter int CNT_W = $clog2(OS)
) (
  input logic               BITCLK,
  input logic               reset,
  receive_state_machine_if.slave bus
);

  logic [2:0] state;
  rxCfg_t     cfg;
  logic [7:0] sh;
  logic [3:0] bitCnt;
  logic       stopCnt;
  logic       pe;
  logic       fe;
  logic [7:0] rxData;
  logic       setRxIfg;
  logic       setPe;
  logic       setFe;
  logic       setOe;
  logic       rxBusy;

  logic       startEdge;
  logic       bitSample;
  logic       bitValid;
  logic       bitEnd;
  logic       run;
  logic       restart;
  logic [7:0] curData;
  logic [3:0] nBits;
  logic       expPar;
  logic       finalStop;
  logic       feNow;
  logic       errNow;

  assign run       = (state != RX_IDLE);
  assign restart   = (state == RX_IDLE) && startEdge;
  assign curData   = alignData(sh, cfg.msb, cfg.sevenBit);
  assign nBits     = cfg.sevenBit ? 4'd7 : 4'd8;
  assign expPar    = (^curData) ^ ~cfg.par;
  assign finalStop = ~cfg.spb | stopCnt;
  assign feNow     = fe | ~bitSample;
  assign errNow    = pe | feNow;

  uart_rx_sampler #(.OS(OS), .CNT_W(CNT_W)) sampler (
    .BITCLK   (BITCLK),
    .reset    (reset),
    .Rx       (bus.Rx),
    .restart  (restart),
    .run      (run),
    .startEdge(startEdge),
    .bitSample(bitSample),
    .bitValid (bitValid),
    .bitEnd   (bitEnd)
  );

  always_ff @(posedge BITCLK or negedge reset) begin
    if (!reset) begin
      state    <= RX_IDLE;
      cfg      <= '0;
      sh       <= '0;
      bitCnt   <= '0;
      stopCnt  <= 1'b0;
      pe       <= 1'b0;
      fe       <= 1'b0;
      rxData   <= '0;
      setRxIfg <= 1'b0;
      setPe    <= 1'b0;
      setFe    <= 1'b0;
      setOe    <= 1'b0;
      rxBusy   <= 1'b0;
    end else begin
      setRxIfg <= 1'b0;
      setPe    <= 1'b0;
      setFe    <= 1'b0;
      setOe    <= 1'b0;
      case (state)
        // Format controls are frozen here so mid-frame writes cannot corrupt it.
        RX_IDLE: begin
          if (startEdge) begin
            state   <= RX_START;
            cfg     <= '{pen: bus.wUCPEN, par: bus.wUCPAR, msb: bus.wUCMSB,
                         sevenBit: bus.wUC7BIT, spb: bus.wUCSPB, rxeie: bus.wUCRXEIE};
            sh      <= '0;
            bitCnt  <= '0;
            stopCnt <= 1'b0;
            pe      <= 1'b0;
            fe      <= 1'b0;
            rxBusy  <= 1'b1;
          end
        end
        RX_START: begin
          if (bitValid && bitSample) begin
            state  <= RX_IDLE;
            rxBusy <= 1'b0;
          end else if (bitEnd) begin
            state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (bitValid) begin
            sh     <= cfg.msb ? {sh[6:0], bitSample} : {bitSample, sh[7:1]};
            bitCnt <= bitCnt + 4'd1;
          end
          if (bitEnd && (bitCnt == nBits))
            state <= cfg.pen ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: begin
          if (bitValid && (bitSample != expPar))
            pe <= 1'b1;
          if (bitEnd)
            state <= RX_STOP;
        end
        // Completion fires at the final stop mid-sample so a back-to-back start edge is not missed.
        RX_STOP: begin
          if (bitValid) begin
            if (finalStop) begin
              state  <= RX_IDLE;
              rxBusy <= 1'b0;
              setPe  <= pe;
              setFe  <= feNow;
              if (!errNow || cfg.rxeie) begin
                rxData   <= curData;
                setRxIfg <= 1'b1;
                setOe    <= bus.iRXIFG;
              end
            end else begin
              fe      <= feNow;
              stopCnt <= 1'b1;
            end
          end
        end
        default: begin
          state  <= RX_IDLE;
          rxBusy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RxData   = rxData;
  assign bus.setRXIFG = setRxIfg;
  assign bus.setUCPE  = setPe;
  assign bus.setUCFE  = setFe;
  assign bus.setUCOE  = setOe;
  assign bus.RxBusy   = rxBusy;

endmodule

// File: tb/tb_receive_state_machine.sv
// Self-checking bench for receive_state_machine: frames are driven bit by bit on Rx,
// expected completions go into a scoreboard queue checked when the strobes fire.
module tb_receive_state_machine;

  localparam int OS = 16;

  typedef struct {
    logic [7:0] data;
    logic       rxifg;
    logic       pe;
    logic       fe;
    logic       oe;
  } expect_t;

  logic BITCLK;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] lastData = 8'h00;
  expect_t expQ[$];
  expect_t monE;

  receive_state_machine_if busIf ();

  receive_state_machine #(.OS(OS), .CNT_W(4)) dut (
    .BITCLK(BITCLK),
    .reset (reset),
    .bus   (busIf)
  );

  initial BITCLK = 1'b0;
  always #5 BITCLK = ~BITCLK;

  // Scoreboard: every completion strobe must match the oldest queued expectation.
  always @(negedge BITCLK) begin
    if (busIf.setRXIFG | busIf.setUCPE | busIf.setUCFE | busIf.setUCOE) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe got rxifg/pe/fe/oe=%b%b%b%b required none",
                 busIf.setRXIFG, busIf.setUCPE, busIf.setUCFE, busIf.setUCOE);
      end else begin
        monE = expQ.pop_front();
        checks++;
        if ({busIf.setRXIFG, busIf.setUCPE, busIf.setUCFE, busIf.setUCOE} !==
            {monE.rxifg, monE.pe, monE.fe, monE.oe}) begin
          errors++;
          $display("[TB] FAIL completion_flags got rxifg/pe/fe/oe=%b%b%b%b required %b%b%b%b",
                   busIf.setRXIFG, busIf.setUCPE, busIf.setUCFE, busIf.setUCOE,
                   monE.rxifg, monE.pe, monE.fe, monE.oe);
        end
        checks++;
        if (busIf.RxData !== monE.data) begin
          errors++;
          $display("[TB] FAIL completion_data got %h required %h", busIf.RxData, monE.data);
        end
      end
    end
  end

  task automatic driveBit(input logic b);
    busIf.Rx = b;
    repeat (OS) @(posedge BITCLK);
    #1;
  endtask

  task automatic setFormat(input bit pen, input bit par, input bit msb, input bit seven,
                           input bit spb, input bit rxeie);
    busIf.wUCPEN   = pen;
    busIf.wUCPAR   = par;
    busIf.wUCMSB   = msb;
    busIf.wUC7BIT  = seven;
    busIf.wUCSPB   = spb;
    busIf.wUCRXEIE = rxeie;
  endtask

  // Builds the frame from the current format, queues the expected outcome, then drives it.
  task automatic sendFrame(input logic [7:0] d, input bit badParity, input logic stopVal);
    logic [7:0] dm;
    logic       ones;
    logic       parBit;
    int         nb;
    expect_t    e;
    nb   = busIf.wUC7BIT ? 7 : 8;
    dm   = busIf.wUC7BIT ? (d & 8'h7F) : d;
    ones = 1'b0;
    for (int i = 0; i < nb; i++) ones = ones ^ dm[i];
    if (busIf.wUCPAR) parBit = ones;
    else              parBit = ~ones;
    if (badParity) parBit = ~parBit;
    e.pe = busIf.wUCPEN && badParity;
    e.fe = (stopVal == 1'b0);
    if (!(e.pe || e.fe) || busIf.wUCRXEIE) begin
      e.data   = dm;
      e.rxifg  = 1'b1;
      e.oe     = busIf.iRXIFG;
      lastData = dm;
    end else begin
      e.data  = lastData;
      e.rxifg = 1'b0;
      e.oe    = 1'b0;
    end
    expQ.push_back(e);
    driveBit(1'b0);
    if (busIf.wUCMSB) for (int i = nb - 1; i >= 0; i--) driveBit(dm[i]);
    else              for (int i = 0; i < nb; i++)      driveBit(dm[i]);
    if (busIf.wUCPEN) driveBit(parBit);
    driveBit(stopVal);
    if (busIf.wUCSPB) driveBit(stopVal);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 4 * OS && expQ.size() != 0; i++) @(posedge BITCLK);
    repeat (2) @(posedge BITCLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge BITCLK);
    #1;
    checks++;
    if ({busIf.RxData, busIf.setRXIFG, busIf.setUCPE, busIf.setUCFE, busIf.setUCOE,
         busIf.RxBusy} !== 13'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got data=%h strobes=%b%b%b%b busy=%b required all 0",
               busIf.RxData, busIf.setRXIFG, busIf.setUCPE, busIf.setUCFE, busIf.setUCOE,
               busIf.RxBusy);
    end
    reset = 1'b1;
    repeat (2 * OS) @(posedge BITCLK);
    #1;
    checks++;
    if (busIf.RxBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_busy got %b required 0", busIf.RxBusy);
    end
  endtask

  task automatic test_basic_8n1();
    setFormat(0, 0, 0, 0, 0, 0);
    fork
      sendFrame(8'hA5, 0, 1'b1);
      begin
        repeat (3 * OS) @(posedge BITCLK);
        #2;
        checks++;
        if (busIf.RxBusy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL busy_midframe got %b required 1", busIf.RxBusy);
        end
      end
    join
    waitDrain();
    checks++;
    if (expQ.size() != 0 || busIf.RxBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done pending=%0d busy=%b required 0/0", expQ.size(), busIf.RxBusy);
    end
  endtask

  task automatic test_7bit_parity_back_to_back();
    setFormat(1, 0, 1, 1, 1, 0);
    sendFrame(8'h35, 0, 1'b1);
    sendFrame(8'h24, 0, 1'b1);
    busIf.Rx = 1'b1;
    waitDrain();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain pending=%0d required 0", expQ.size());
    end
  endtask

  task automatic test_parity_error();
    setFormat(1, 1, 0, 0, 0, 0);
    sendFrame(8'h55, 1, 1'b1);
    waitDrain();
    checks++;
    if (busIf.RxData !== 8'h24) begin
      errors++;
      $display("[TB] FAIL pe_data_held got %h required 24", busIf.RxData);
    end
    busIf.wUCRXEIE = 1'b1;
    sendFrame(8'h55, 1, 1'b1);
    waitDrain();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pe_drain pending=%0d required 0", expQ.size());
    end
  endtask

  task automatic test_framing_break();
    setFormat(0, 0, 0, 0, 0, 0);
    sendFrame(8'h3C, 0, 1'b0);
    repeat (40 * OS) @(posedge BITCLK);
    #1;
    checks++;
    if (expQ.size() != 0 || busIf.RxBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL break_quiet pending=%0d busy=%b required 0/0", expQ.size(), busIf.RxBusy);
    end
    busIf.Rx = 1'b1;
    repeat (2 * OS) @(posedge BITCLK);
    #1;
    sendFrame(8'h81, 0, 1'b1);
    waitDrain();
    checks++;
    if (busIf.RxData !== 8'h81) begin
      errors++;
      $display("[TB] FAIL after_break_data got %h required 81", busIf.RxData);
    end
  endtask

  task automatic test_glitch_overrun();
    int busyCycles;
    busyCycles = 0;
    busIf.Rx = 1'b0;
    for (int i = 0; i < 2 * OS; i++) begin
      @(negedge BITCLK);
      if (i == 2) busIf.Rx = 1'b1;
      if (busIf.RxBusy) busyCycles++;
    end
    checks++;
    if (busyCycles == 0 || busyCycles >= OS || busIf.RxBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_busy got cycles=%0d busy=%b required 1..%0d and 0", busyCycles,
               busIf.RxBusy, OS - 1);
    end
    checks++;
    if (busIf.RxData !== 8'h81) begin
      errors++;
      $display("[TB] FAIL glitch_data got %h required 81", busIf.RxData);
    end
    @(posedge BITCLK);
    #1;
    busIf.iRXIFG = 1'b1;
    sendFrame(8'h12, 0, 1'b1);
    waitDrain();
    busIf.iRXIFG = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL overrun_drain pending=%0d required 0", expQ.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    setFormat(0, 0, 0, 0, 0, 0);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    checks++;
    if (busIf.RxBusy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_before_reset got %b required 1", busIf.RxBusy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busIf.RxData, busIf.setRXIFG, busIf.setUCPE, busIf.setUCFE, busIf.setUCOE,
         busIf.RxBusy} !== 13'h0) begin
      errors++;
      $display("[TB] FAIL midframe_reset got data=%h busy=%b required 0/0", busIf.RxData,
               busIf.RxBusy);
    end
    busIf.Rx = 1'b1;
    repeat (4) @(posedge BITCLK);
    #1;
    reset = 1'b1;
    lastData = 8'h00;
    repeat (2 * OS) @(posedge BITCLK);
    #1;
    sendFrame(8'hC3, 0, 1'b1);
    waitDrain();
    checks++;
    if (busIf.RxData !== 8'hC3 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_frame got %h pending=%0d required c3/0", busIf.RxData,
               expQ.size());
    end
  endtask

  initial begin
    reset        = 1'b0;
    busIf.Rx     = 1'b1;
    busIf.iRXIFG = 1'b0;
    setFormat(0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_basic_8n1();
    test_7bit_parity_back_to_back();
    test_parity_error();
    test_framing_break();
    test_glitch_overrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
